// File: rtl/prbs7_checker.sv
// PRBS7 (x^7 + x^6 + 1, XNOR feedback) receive-side checker.
// It hunts for alignment by loading received bits, verifies that the
// stream matches its own prediction for LOCK_CNT bits, then locks.
// Once locked it free-runs and counts mismatches. Too many errors in
// one observation window send it back to hunting.
`timescale 1ns/1ps

module prbs7_checker #(
   parameter int LOCK_CNT = 16,
   parameter int WIN      = 64,
   parameter int LOSS_ERR = 8,
   parameter int ERRW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            din,
   input  logic            din_valid,
   input  logic            err_clr,
   output logic            locked,
   output logic            err,
   output logic [ERRW-1:0] err_cnt
);

   localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
   localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int EW = (LOSS_ERR > 1) ? $clog2(LOSS_ERR + 1) : 1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [6:0]      sr;
   logic [6:0]      sr_nxt;
   logic [2:0]      fill_cnt;
   logic [2:0]      fill_nxt;
   logic [MW-1:0]   match_cnt;
   logic [MW-1:0]   match_nxt;
   logic [WW-1:0]   win_cnt;
   logic [WW-1:0]   win_nxt;
   logic [EW-1:0]   win_err_cnt;
   logic [EW-1:0]   win_err_nxt;
   logic [ERRW-1:0] err_cnt_nxt;
   logic            err_nxt;
   logic            locked_nxt;
   logic            pred;
   logic            counted_err;

   // State and counter registers; reset forces a clean hunt immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= HUNT;
         sr          <= '0;
         fill_cnt    <= '0;
         match_cnt   <= '0;
         win_cnt     <= '0;
         win_err_cnt <= '0;
         err_cnt     <= '0;
         err         <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nxt;
         sr          <= sr_nxt;
         fill_cnt    <= fill_nxt;
         match_cnt   <= match_nxt;
         win_cnt     <= win_nxt;
         win_err_cnt <= win_err_nxt;
         err_cnt     <= err_cnt_nxt;
         err         <= err_nxt;
         locked      <= locked_nxt;
      end
   end

   // Next-state logic: hunt/verify shift in received bits, locked free-runs.
   always_comb begin
      pred        = ~(sr[6] ^ sr[5]);
      state_nxt   = state;
      sr_nxt      = sr;
      fill_nxt    = fill_cnt;
      match_nxt   = match_cnt;
      win_nxt     = win_cnt;
      win_err_nxt = win_err_cnt;
      err_nxt     = 1'b0;
      counted_err = 1'b0;

      case (state)
         HUNT: begin
            if (din_valid) begin
               sr_nxt = {sr[5:0], din};
               if (fill_cnt == 3'd6) begin
                  fill_nxt  = '0;
                  state_nxt = VERIFY;
               end else begin
                  fill_nxt = fill_cnt + 3'd1;
               end
            end
         end

         VERIFY: begin
            if (din_valid) begin
               sr_nxt = {sr[5:0], din};
               if (din == pred) begin
                  // A match in the all-ones lock-up state proves nothing.
                  if (sr != 7'h7F) begin
                     if (match_cnt == MW'(LOCK_CNT - 1)) begin
                        state_nxt   = LOCKED;
                        match_nxt   = '0;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                     end else begin
                        match_nxt = match_cnt + MW'(1);
                     end
                  end
               end else begin
                  match_nxt = '0;
               end
            end
         end

         LOCKED: begin
            if (din_valid) begin
               sr_nxt = {sr[5:0], pred};
               if (din != pred) begin
                  counted_err = 1'b1;
                  err_nxt     = 1'b1;
                  win_err_nxt = win_err_cnt + EW'(1);
               end
               if (win_cnt == WW'(WIN - 1)) begin
                  win_nxt     = '0;
                  win_err_nxt = '0;
               end else begin
                  win_nxt = win_cnt + WW'(1);
               end
               // Loss of lock wins over a simultaneous window clear.
               if (counted_err && (win_err_cnt == EW'(LOSS_ERR - 1))) begin
                  state_nxt   = HUNT;
                  fill_nxt    = '0;
                  match_nxt   = '0;
                  win_nxt     = '0;
                  win_err_nxt = '0;
               end
            end
         end

         default: begin
            state_nxt = HUNT;
         end
      endcase

      locked_nxt = (state_nxt == LOCKED);

      err_cnt_nxt = err_cnt;
      if (counted_err && (err_cnt != '1)) begin
         err_cnt_nxt = err_cnt + ERRW'(1);
      end
      if (err_clr) begin
         err_cnt_nxt = ERRW'(counted_err);
      end
   end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed testbench for prbs7_checker. A reference XNOR PRBS7 generator
// seeded with 7'h00 supplies the clean stream; errors are injected by
// inverting chosen bits. The error counter is built 4 bits wide here so
// that saturation at all ones is reachable in a short run.
`timescale 1ns/1ps

module tb_prbs7_checker;

   logic       clk;
   logic       rst;
   logic       din;
   logic       din_valid;
   logic       err_clr;
   logic       locked;
   logic       err;
   logic [3:0] err_cnt;

   logic [6:0] gen;
   int         n_compared;
   int         n_mismatched;
   int         err_pulses;
   int         lock_seen;

   prbs7_checker #(
      .LOCK_CNT(16),
      .WIN(64),
      .LOSS_ERR(8),
      .ERRW(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .din_valid(din_valid),
      .err_clr(err_clr),
      .locked(locked),
      .err(err),
      .err_cnt(err_cnt)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, sample #1 after the rising edge.
   task automatic applyStimulus(input logic d, input logic v, input logic clr);
      @(negedge clk);
      din       = d;
      din_valid = v;
      err_clr   = clr;
      @(posedge clk);
      #1;
      if (err === 1'b1) err_pulses++;
      if (locked === 1'b1) lock_seen++;
   endtask

   // Send the next reference bit, optionally inverted.
   task automatic sendBit(input logic flip, input logic clr);
      logic b;
      b   = ~(gen[6] ^ gen[5]);
      gen = {gen[5:0], b};
      applyStimulus(b ^ flip, 1'b1, clr);
   endtask

   task automatic sendClean(input int n);
      for (int i = 0; i < n; i++) sendBit(1'b0, 1'b0);
   endtask

   // Pulse reset across a falling edge and resume with idle inputs.
   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      din_valid = 1'b0;
      err_clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      err_pulses   = 0;
      lock_seen    = 0;
      gen          = 7'h00;
      rst          = 1'b1;
      din          = 1'b0;
      din_valid    = 1'b0;
      err_clr      = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      // Clean stream: lock on the edge accepting bit 23.
      sendClean(22);
      checkOutput("clean_no_lock_at_22", 32'(lock_seen), 32'd0);
      sendClean(1);
      checkOutput("clean_lock_at_23", 32'(locked), 32'd1);
      checkOutput("clean_no_err", 32'(err_pulses), 32'd0);
      checkOutput("clean_err_cnt", 32'(err_cnt), 32'd0);

      // Single flipped bit at window position 0.
      sendBit(1'b1, 1'b0);
      checkOutput("single_err_pulse", 32'(err), 32'd1);
      checkOutput("single_err_cnt", 32'(err_cnt), 32'd1);
      checkOutput("single_locked", 32'(locked), 32'd1);
      err_pulses = 0;
      sendClean(10);
      checkOutput("single_no_more_err", 32'(err_pulses), 32'd0);
      checkOutput("single_err_low", 32'(err), 32'd0);

      // Finish the first window (positions 11..63).
      sendClean(53);

      // New window: clear on a clean bit, then 8 errors drop lock.
      sendBit(1'b0, 1'b1);
      checkOutput("clr_clean", 32'(err_cnt), 32'd0);
      for (int i = 0; i < 7; i++) begin
         sendBit(1'b1, 1'b0);
         sendBit(1'b0, 1'b0);
      end
      checkOutput("loss7_locked", 32'(locked), 32'd1);
      checkOutput("loss7_err_cnt", 32'(err_cnt), 32'd7);
      sendBit(1'b1, 1'b0);
      checkOutput("loss8_unlocked", 32'(locked), 32'd0);
      checkOutput("loss8_err_cnt", 32'(err_cnt), 32'd8);
      checkOutput("loss8_err_pulse", 32'(err), 32'd1);

      // Relock after 23 clean bits.
      lock_seen = 0;
      sendClean(22);
      checkOutput("relock_none_at_22", 32'(lock_seen), 32'd0);
      sendClean(1);
      checkOutput("relock_at_23", 32'(locked), 32'd1);

      // Window n: 7 errors, the first with a concurrent clear.
      sendBit(1'b1, 1'b1);
      checkOutput("clr_with_err", 32'(err_cnt), 32'd1);
      for (int i = 0; i < 6; i++) begin
         sendBit(1'b0, 1'b0);
         sendBit(1'b1, 1'b0);
      end
      sendClean(51);
      checkOutput("winn_locked", 32'(locked), 32'd1);
      checkOutput("winn_err_cnt", 32'(err_cnt), 32'd7);
      // Window n+1: 7 more errors, lock must hold.
      for (int i = 0; i < 7; i++) begin
         sendBit(1'b1, 1'b0);
         sendBit(1'b0, 1'b0);
      end
      checkOutput("winn1_locked", 32'(locked), 32'd1);
      checkOutput("winn1_err_cnt", 32'(err_cnt), 32'd14);
      sendClean(49);
      checkOutput("winn1_pos62_locked", 32'(locked), 32'd1);
      // 8th error on the window-completing bit: loss wins.
      sendBit(1'b1, 1'b0);
      checkOutput("winend_loss", 32'(locked), 32'd0);
      checkOutput("winend_err_cnt_sat", 32'(err_cnt), 32'd15);

      // Saturation and clear-with-error while locked again.
      sendClean(23);
      checkOutput("sat_relock", 32'(locked), 32'd1);
      sendBit(1'b1, 1'b0);
      checkOutput("sat_err_pulse", 32'(err), 32'd1);
      checkOutput("sat_hold", 32'(err_cnt), 32'd15);
      sendBit(1'b0, 1'b0);
      checkOutput("sat_err_low", 32'(err), 32'd0);
      sendBit(1'b1, 1'b1);
      checkOutput("sat_clr_with_err", 32'(err_cnt), 32'd1);
      sendBit(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("invalid_err_low", 32'(err), 32'd0);
      checkOutput("invalid_err_cnt_hold", 32'(err_cnt), 32'd2);
      checkOutput("invalid_locked", 32'(locked), 32'd1);

      // Reset pulse between edges while locked.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_locked", 32'(locked), 32'd0);
      checkOutput("async_rst_err_cnt", 32'(err_cnt), 32'd0);
      #1;
      rst = 1'b0;
      lock_seen = 0;
      sendClean(22);
      checkOutput("post_rst_none_at_22", 32'(lock_seen), 32'd0);
      sendClean(1);
      checkOutput("post_rst_lock_at_23", 32'(locked), 32'd1);

      // Garbage then all-ones in HUNT/VERIFY: never lock, never err.
      pulseReset();
      lock_seen  = 0;
      err_pulses = 0;
      for (int i = 0; i < 20; i++) applyStimulus(logic'(i % 2 == 0), 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("ones_never_lock", 32'(lock_seen), 32'd0);
      checkOutput("hunt_no_err", 32'(err_pulses), 32'd0);
      checkOutput("hunt_err_cnt", 32'(err_cnt), 32'd0);

      // Clean stream with random din_valid gaps: still 23 valid bits.
      pulseReset();
      lock_seen = 0;
      for (int i = 0; i < 23; i++) begin
         if (i == 22) checkOutput("gaps_none_at_22", 32'(lock_seen), 32'd0);
         sendBit(1'b0, 1'b0);
         if (i < 22) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
               applyStimulus(logic'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
         end
      end
      checkOutput("gaps_lock_at_23", 32'(locked), 32'd1);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive correct bits in VERIFY needed to declare lock.
REQ-002 Parameter WIN, default 64: length, in valid bits, of the loss-of-lock observation window.
REQ-003 Parameter LOSS_ERR, default 8: mismatches within one window that force loss of lock.
REQ-004 Parameter ERRW, default 16: width of the error counter.
REQ-005 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port din, input, 1: received serial PRBS bit.
REQ-008 Port din_valid, input, 1: din is sampled only on edges where this is 1; otherwise all state holds.
REQ-009 Port err_clr, input, 1: synchronous clear of err_cnt.
REQ-010 Port locked, output, 1: registered; 1 while the state is LOCKED.
REQ-011 Port err, output, 1: registered one-cycle pulse marking a mismatch detected in LOCKED.
REQ-012 Port err_cnt, output, ERRW: registered, saturating count of mismatches detected in LOCKED.

Function
REQ-013 The checker shall model PRBS7 x^7+x^6+1 with XNOR feedback, using a 7-bit register sr[6:0].
REQ-014 Shifting shall be sr <= {sr[5:0], b}, and the predicted next bit shall be p = sr[6] XNOR sr[5].
REQ-015 States shall be HUNT, VERIFY and LOCKED.
REQ-016 HUNT shall shift the received din into sr on each valid bit.
REQ-017 HUNT shall move to VERIFY on the edge that accepts the 7th valid bit, with the fill counter reset to 0.
REQ-018 VERIFY shall compare din with p on each valid bit and shift the received din into sr (self-synchronising).
REQ-019 In VERIFY, a match shall increment the match counter and a mismatch shall clear it; the state stays VERIFY.
REQ-020 The match counter shall not advance while sr == 7'h7F, the XNOR lock-up state.
REQ-021 VERIFY shall move to LOCKED on the edge where the match counter reaches LOCK_CNT.
REQ-022 locked shall become 1 at that same edge, after 7+LOCK_CNT valid bits (23 with defaults) of clean stream.
REQ-023 LOCKED shall shift the predicted bit p into sr (free-running), so that line errors do not propagate.
REQ-024 In LOCKED, a mismatch (din != p) shall set err=1 for exactly one cycle, increment err_cnt and increment the window error count.
REQ-025 In LOCKED, err shall be 0 on every edge without a mismatch, including edges where din_valid=0.
REQ-026 In LOCKED, the window counter shall count valid bits 0..WIN-1.
REQ-027 The bit that completes a window shall be counted in that window; the window counter and window error count then clear together.
REQ-028 When the window error count reaches LOSS_ERR, the state shall return to HUNT at that edge.
REQ-029 On loss of lock, locked shall go to 0 and the fill, match, window and window-error counters shall clear; err_cnt is retained.
REQ-030 If the LOSS_ERR-th mismatch falls on the window-completing bit, loss of lock shall take priority over the window clear.
REQ-031 err_cnt shall saturate at all ones and never wrap.
REQ-032 err_clr takes effect regardless of din_valid and state.
REQ-033 If err_clr coincides with a counted mismatch, err_cnt shall become 1.
REQ-034 Mismatches in HUNT or VERIFY shall not assert err or change err_cnt.

Reset
REQ-035 Asserting rst shall immediately force state HUNT, clear sr and all counters, and drive locked=0, err=0 and err_cnt=0, without waiting for clk.
REQ-036 Asserting rst mid-lock shall drop locked immediately; after release the checker shall require the full 7+LOCK_CNT valid bits to relock.

Verification
REQ-037 Clean PRBS7 stream (bench XNOR model seeded 7'h00), din_valid=1 every cycle -> locked=1 on the edge accepting bit 23, err never 1, err_cnt=0.
REQ-038 Locked, single flipped bit -> one err pulse, err_cnt=1, locked stays 1, and the following bits match with no further err.
REQ-039 Locked, 8 flipped bits within one 64-bit window -> err_cnt=8, locked drops on the 8th error; then a clean stream relocks after 23 bits.
REQ-040 Locked, 7 errors in window n and 7 in window n+1 -> locked stays 1, err_cnt=14.
REQ-041 err_cnt preset to 16'hFFFF by forced errors, further error -> stays 16'hFFFF; err_clr concurrent with a mismatch -> err_cnt=1.
REQ-042 All-ones din in HUNT/VERIFY -> locked never asserts; din_valid gaps of random length in a clean stream -> same lock bit count as REQ-037; rst pulse between clock edges while locked -> locked=0 before the next edge.
